// File: rtl/counter_interval_arbiter_if.sv
// Bundle of signals between requesters, the interval arbiter and the shared
// loadable up-counter. The master side is the requester/counter environment,
// and the slave side is the arbiter itself.
interface counter_interval_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_len;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic              cnt_ld;
   logic [W-1:0]      cnt_ldvalue;
   logic [W-1:0]      cnt_dout;

   modport master (
      output req, req_len, cnt_dout,
      input  grant, done, busy, cnt_ld, cnt_ldvalue
   );

   modport slave (
      input  req, req_len, cnt_dout,
      output grant, done, busy, cnt_ld, cnt_ldvalue
   );
endinterface

// File: rtl/counter_interval_arbiter.sv
// Round-robin arbiter that lends one external loadable up-counter to NREQ
// requesters. Each winner gets its requested interval timed by preloading
// the counter with ~len and waiting for the all-ones terminal count, then
// receives a one-cycle done pulse.
module counter_interval_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input logic clk,
   input logic rst,
   counter_interval_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t          state;
   logic [NREQ-1:0] grant_q;
   logic [NREQ-1:0] done_q;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   ptr;
   logic [W-1:0]    len_q;

   logic            pick_valid;
   logic [PW-1:0]   pick_idx;
   logic [W-1:0]    pick_len;
   int              idx;

   // Search upward from the requester after the last owner so every other
   // pending requester is served before the last owner can win again.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      pick_len   = '0;
      idx        = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!pick_valid && bus.req[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = PW'(idx);
            pick_len   = bus.req_len[idx*W +: W];
         end
      end
   end

   // Main controller: arbitration, counter preload, terminal-count watch and
   // the done pulse, all held in registers that reset straight to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         owner   <= '0;
         ptr     <= PW'(NREQ - 1);
         len_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= '0;
               if (pick_valid) begin
                  owner   <= pick_idx;
                  len_q   <= pick_len;
                  grant_q <= NREQ'(1) << pick_idx;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               state <= RUN;
            end
            RUN: begin
               if (bus.cnt_dout == {W{1'b1}}) begin
                  done_q <= NREQ'(1) << owner;
                  state  <= FIN;
               end
            end
            FIN: begin
               ptr     <= owner;
               grant_q <= '0;
               done_q  <= '0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Counter control is a pure decode of state: park at zero while idle,
   // preload ~len for one cycle, then let the counter run freely.
   always_comb begin
      bus.cnt_ld      = (state == IDLE) || (state == LOAD);
      bus.cnt_ldvalue = (state == LOAD) ? ~len_q : '0;
      bus.busy        = (state != IDLE);
      bus.grant       = grant_q;
      bus.done        = done_q;
   end
endmodule
